// File: rtl/riscv_counter_ctrl.sv
// Machine-counter controller: decodes CSR accesses to mcycle/minstret/mcountinhibit,
// drives the write and increment controls of both external counters and returns read data.
module riscv_counter_ctrl #(
    parameter int CNT_W  = 64,
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              csr_req_i,
    input  logic [ADDR_W-1:0] csr_addr_i,
    input  logic [1:0]        csr_op_i,
    input  logic [CNT_W-1:0]  csr_wdata_i,
    output logic              csr_ack_o,
    output logic [CNT_W-1:0]  csr_rdata_o,
    output logic              csr_illegal_o,
    input  logic              retire_i,
    input  logic              halt_i,
    input  logic [CNT_W-1:0]  cyc_value_i,
    input  logic [CNT_W-1:0]  ret_value_i,
    output logic              cyc_incr_en_o,
    output logic              cyc_write_en_o,
    output logic [CNT_W-1:0]  cyc_wdata_o,
    output logic              ret_incr_en_o,
    output logic              ret_write_en_o,
    output logic [CNT_W-1:0]  ret_wdata_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        ACK  = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] A_MCYCLE   = ADDR_W'(12'hB00);
    localparam logic [ADDR_W-1:0] A_MINSTRET = ADDR_W'(12'hB02);
    localparam logic [ADDR_W-1:0] A_MCNTINH  = ADDR_W'(12'h320);
    localparam logic [ADDR_W-1:0] A_CYCLE    = ADDR_W'(12'hC00);
    localparam logic [ADDR_W-1:0] A_INSTRET  = ADDR_W'(12'hC02);

    localparam logic [1:0] OP_READ  = 2'b00;
    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;

    state_t             state, state_nxt;
    logic [ADDR_W-1:0]  addr_q;
    logic [1:0]         op_q;
    logic [CNT_W-1:0]   wdata_q;
    logic               inh_cy, inh_ir;
    logic [CNT_W-1:0]   rdata_q;
    logic               illegal_q;

    logic [CNT_W-1:0]   old_val, new_val;
    logic               is_known, is_ro, is_write, illegal;
    logic               wr_cyc, wr_ret, wr_inh;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves a signal unassigned and infers a latch.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (csr_req_i) state_nxt = EXEC;
            EXEC:    state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        old_val  = '0;
        is_known = 1'b1;
        is_ro    = 1'b0;
        case (addr_q)
            A_MCYCLE:   old_val = cyc_value_i;
            A_MINSTRET: old_val = ret_value_i;
            A_MCNTINH:  old_val = CNT_W'({inh_ir, 1'b0, inh_cy});
            A_CYCLE: begin
                old_val = cyc_value_i;
                is_ro   = 1'b1;
            end
            A_INSTRET: begin
                old_val = ret_value_i;
                is_ro   = 1'b1;
            end
            default:    is_known = 1'b0;
        endcase

        case (op_q)
            OP_READ:  new_val = old_val;
            OP_WRITE: new_val = wdata_q;
            OP_SET:   new_val = old_val | wdata_q;
            default:  new_val = old_val & ~wdata_q;
        endcase

        // Set/clear with a zero operand never modifies anything, so it is a read.
        is_write = (op_q == OP_WRITE) || (op_q[1] && (wdata_q != '0));
        illegal  = !is_known || (is_write && is_ro);

        wr_cyc = (state == EXEC) && is_write && !illegal && (addr_q == A_MCYCLE);
        wr_ret = (state == EXEC) && is_write && !illegal && (addr_q == A_MINSTRET);
        wr_inh = (state == EXEC) && is_write && !illegal && (addr_q == A_MCNTINH);
    end

    assign cyc_write_en_o = wr_cyc;
    assign ret_write_en_o = wr_ret;
    assign cyc_wdata_o    = wr_cyc ? new_val : '0;
    assign ret_wdata_o    = wr_ret ? new_val : '0;

    // A CSR write owns the counter for its cycle, so that cycle's increment is dropped.
    assign cyc_incr_en_o = rst && !inh_cy && !halt_i && !wr_cyc;
    assign ret_incr_en_o = rst && retire_i && !inh_ir && !halt_i && !wr_ret;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            addr_q  <= '0;
            op_q    <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && csr_req_i) begin
            addr_q  <= csr_addr_i;
            op_q    <= csr_op_i;
            wdata_q <= csr_wdata_i;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inh_cy <= 1'b0;
            inh_ir <= 1'b0;
        end else if (wr_inh) begin
            inh_cy <= new_val[0];
            inh_ir <= new_val[2];
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata_q   <= '0;
            illegal_q <= 1'b0;
        end else if (state == EXEC) begin
            rdata_q   <= illegal ? '0 : old_val;
            illegal_q <= illegal;
        end
    end

    assign csr_ack_o     = (state == ACK);
    assign csr_rdata_o   = rdata_q;
    assign csr_illegal_o = illegal_q;

endmodule

// File: tb/tb_riscv_counter_ctrl.sv
// Self-checking bench for riscv_counter_ctrl: directed vector table, reset corner
// cases and randomized accesses against a behavioural CSR model.
module tb_riscv_counter_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        csr_req_i = 1'b0;
    logic [11:0] csr_addr_i = '0;
    logic [1:0]  csr_op_i = '0;
    logic [63:0] csr_wdata_i = '0;
    logic        csr_ack_o;
    logic [63:0] csr_rdata_o;
    logic        csr_illegal_o;
    logic        retire_i = 1'b0;
    logic        halt_i = 1'b0;
    logic [63:0] cyc_value_i = '0;
    logic [63:0] ret_value_i = '0;
    logic        cyc_incr_en_o, cyc_write_en_o, ret_incr_en_o, ret_write_en_o;
    logic [63:0] cyc_wdata_o, ret_wdata_o;

    riscv_counter_ctrl #(.CNT_W(64), .ADDR_W(12)) dut (
        .clk(clk), .rst(rst),
        .csr_req_i(csr_req_i), .csr_addr_i(csr_addr_i), .csr_op_i(csr_op_i),
        .csr_wdata_i(csr_wdata_i), .csr_ack_o(csr_ack_o), .csr_rdata_o(csr_rdata_o),
        .csr_illegal_o(csr_illegal_o), .retire_i(retire_i), .halt_i(halt_i),
        .cyc_value_i(cyc_value_i), .ret_value_i(ret_value_i),
        .cyc_incr_en_o(cyc_incr_en_o), .cyc_write_en_o(cyc_write_en_o),
        .cyc_wdata_o(cyc_wdata_o), .ret_incr_en_o(ret_incr_en_o),
        .ret_write_en_o(ret_write_en_o), .ret_wdata_o(ret_wdata_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] addr;
        logic [1:0]  op;
        logic [63:0] wdata, cyc, ret;
        logic        retire, halt;
        logic [63:0] rdata;
        logic        ill, cyc_we, ret_we;
        logic [63:0] wval;
        logic [2:0]  inh;   // mcountinhibit image after the access
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;
    logic [2:0] m_inh = 3'b000;
    vec_t tbl[13];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives one access and checks the IDLE, EXEC and ACK cycles.
    task automatic run_access(input vec_t v, input string tag);
        logic e_cinc, e_rinc;
        @(negedge clk);
        csr_req_i = 1'b1; csr_addr_i = v.addr; csr_op_i = v.op; csr_wdata_i = v.wdata;
        cyc_value_i = v.cyc; ret_value_i = v.ret; retire_i = v.retire; halt_i = v.halt;
        #1 check({tag, " idle_ack"}, 64'(csr_ack_o), 64'd0);

        @(negedge clk);
        e_cinc = !m_inh[0] && !v.halt && !v.cyc_we;
        e_rinc = v.retire && !m_inh[2] && !v.halt && !v.ret_we;
        check({tag, " exec_cyc_we"}, 64'(cyc_write_en_o), 64'(v.cyc_we));
        check({tag, " exec_ret_we"}, 64'(ret_write_en_o), 64'(v.ret_we));
        if (v.cyc_we) check({tag, " exec_cyc_wdata"}, cyc_wdata_o, v.wval);
        if (v.ret_we) check({tag, " exec_ret_wdata"}, ret_wdata_o, v.wval);
        check({tag, " exec_cyc_incr"}, 64'(cyc_incr_en_o), 64'(e_cinc));
        check({tag, " exec_ret_incr"}, 64'(ret_incr_en_o), 64'(e_rinc));
        check({tag, " exec_ack"}, 64'(csr_ack_o), 64'd0);
        m_inh = v.inh;

        @(negedge clk);
        check({tag, " ack"}, 64'(csr_ack_o), 64'd1);
        check({tag, " rdata"}, csr_rdata_o, v.rdata);
        check({tag, " illegal"}, 64'(csr_illegal_o), 64'(v.ill));
        check({tag, " ack_we"}, 64'({cyc_write_en_o, ret_write_en_o}), 64'd0);
        check({tag, " ack_cyc_incr"}, 64'(cyc_incr_en_o), 64'(!m_inh[0] && !v.halt));
        check({tag, " ack_ret_incr"}, 64'(ret_incr_en_o), 64'(v.retire && !m_inh[2] && !v.halt));
        csr_req_i = 1'b0;
    endtask

    // Reference model: expected results from the CSR rules and the current inhibit image.
    function automatic vec_t model(input vec_t v);
        vec_t r = v;
        logic [63:0] old_v = '0, new_v;
        logic known = 1'b1, ro = 1'b0, wr;
        case (v.addr)
            12'hB00: old_v = v.cyc;
            12'hB02: old_v = v.ret;
            12'h320: old_v = {61'd0, m_inh & 3'b101};
            12'hC00: begin old_v = v.cyc; ro = 1'b1; end
            12'hC02: begin old_v = v.ret; ro = 1'b1; end
            default: known = 1'b0;
        endcase
        new_v = (v.op == 2'b00) ? old_v : (v.op == 2'b01) ? v.wdata :
                (v.op == 2'b10) ? (old_v | v.wdata) : (old_v & ~v.wdata);
        wr = (v.op == 2'b01) || (v.op >= 2'b10 && v.wdata != 0);
        r.ill    = !known || (wr && ro);
        r.rdata  = r.ill ? 64'd0 : old_v;
        r.cyc_we = !r.ill && wr && v.addr == 12'hB00;
        r.ret_we = !r.ill && wr && v.addr == 12'hB02;
        r.wval   = new_v;
        r.inh    = (!r.ill && wr && v.addr == 12'h320) ? (new_v[2:0] & 3'b101) : m_inh;
        return r;
    endfunction

    initial begin
        vec_t v;
        logic [11:0] addr_pool[6];
        //           addr     op     wdata       cyc         ret        rt    hl    rdata        ill   cwe   rwe   wval        inh
        tbl[0]  = '{12'hB00, 2'b01, 64'h100,    64'h40,     64'h0,     1'b0, 1'b0, 64'h40,     1'b0, 1'b1, 1'b0, 64'h100,    3'b000};
        tbl[1]  = '{12'h320, 2'b10, 64'h5,      64'h0,      64'h0,     1'b1, 1'b0, 64'h0,      1'b0, 1'b0, 1'b0, 64'h0,      3'b101};
        tbl[2]  = '{12'h320, 2'b00, 64'h0,      64'h0,      64'h0,     1'b1, 1'b0, 64'h5,      1'b0, 1'b0, 1'b0, 64'h0,      3'b101};
        tbl[3]  = '{12'h320, 2'b01, 64'hFFFF,   64'h0,      64'h0,     1'b0, 1'b0, 64'h5,      1'b0, 1'b0, 1'b0, 64'h0,      3'b101};
        tbl[4]  = '{12'h320, 2'b00, 64'h0,      64'h0,      64'h0,     1'b0, 1'b0, 64'h5,      1'b0, 1'b0, 1'b0, 64'h0,      3'b101};
        tbl[5]  = '{12'hC02, 2'b01, 64'h1,      64'h0,      64'h3,     1'b0, 1'b0, 64'h0,      1'b1, 1'b0, 1'b0, 64'h0,      3'b101};
        tbl[6]  = '{12'hC02, 2'b00, 64'h0,      64'h0,      64'h7,     1'b0, 1'b0, 64'h7,      1'b0, 1'b0, 1'b0, 64'h0,      3'b101};
        tbl[7]  = '{12'h320, 2'b11, 64'h5,      64'h0,      64'h0,     1'b0, 1'b0, 64'h5,      1'b0, 1'b0, 1'b0, 64'h0,      3'b000};
        tbl[8]  = '{12'hB02, 2'b11, 64'hFF,     64'h0,      64'h1234,  1'b1, 1'b0, 64'h1234,   1'b0, 1'b0, 1'b1, 64'h1200,   3'b000};
        tbl[9]  = '{12'hB02, 2'b11, 64'h0,      64'h0,      64'h55,    1'b1, 1'b0, 64'h55,     1'b0, 1'b0, 1'b0, 64'h0,      3'b000};
        tbl[10] = '{12'h123, 2'b00, 64'h0,      64'h9,      64'h9,     1'b0, 1'b0, 64'h0,      1'b1, 1'b0, 1'b0, 64'h0,      3'b000};
        tbl[11] = '{12'hC00, 2'b10, 64'h0,      64'h99,     64'h0,     1'b0, 1'b1, 64'h99,     1'b0, 1'b0, 1'b0, 64'h0,      3'b000};
        tbl[12] = '{12'h321, 2'b01, 64'h1,      64'h0,      64'h0,     1'b1, 1'b0, 64'h0,      1'b1, 1'b0, 1'b0, 64'h0,      3'b000};
        addr_pool = '{12'hB00, 12'hB02, 12'h320, 12'hC00, 12'hC02, 12'h000};

        // Reset state.
        #2;
        check("rst_ack", 64'(csr_ack_o), 64'd0);
        check("rst_illegal", 64'(csr_illegal_o), 64'd0);
        check("rst_rdata", csr_rdata_o, 64'd0);
        check("rst_we", 64'({cyc_write_en_o, ret_write_en_o}), 64'd0);
        check("rst_wdata", cyc_wdata_o | ret_wdata_o, 64'd0);
        check("rst_incr", 64'({cyc_incr_en_o, ret_incr_en_o}), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("idle_cyc_incr", 64'(cyc_incr_en_o), 64'd1);
            check("idle_ret_incr", 64'(ret_incr_en_o), 64'd0);
            check("idle_we", 64'({cyc_write_en_o, ret_write_en_o}), 64'd0);
            check("idle_ack", 64'(csr_ack_o), 64'd0);
        end

        for (int i = 0; i < 13; i++) run_access(tbl[i], $sformatf("vec%0d", i));

        // Inhibit CY, then reset in the middle of a write to mcycle.
        v = '{12'h320, 2'b01, 64'h1, 64'h0, 64'h0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0, 1'b0, 64'h0, 3'b001};
        run_access(v, "inh_cy");
        @(negedge clk);
        csr_req_i = 1'b1; csr_addr_i = 12'hB00; csr_op_i = 2'b01; csr_wdata_i = 64'hABC;
        retire_i = 1'b0; halt_i = 1'b0;
        @(negedge clk);
        check("midrst_exec_we", 64'(cyc_write_en_o), 64'd1);
        rst = 1'b0;
        #1;
        check("midrst_we", 64'({cyc_write_en_o, ret_write_en_o}), 64'd0);
        check("midrst_ack", 64'(csr_ack_o), 64'd0);
        check("midrst_incr", 64'({cyc_incr_en_o, ret_incr_en_o}), 64'd0);
        csr_req_i = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("inrst_ack", 64'(csr_ack_o), 64'd0);
        end
        rst = 1'b1;
        m_inh = 3'b000;
        @(negedge clk);
        check("postrst_cyc_incr", 64'(cyc_incr_en_o), 64'd1);
        check("postrst_ack", 64'(csr_ack_o), 64'd0);
        v = '{12'hB00, 2'b01, 64'hABC, 64'h77, 64'h0, 1'b0, 1'b0, 64'h77, 1'b0, 1'b1, 1'b0, 64'hABC, 3'b000};
        run_access(v, "postrst");

        // Randomized accesses against the model.
        for (int i = 0; i < 300; i++) begin
            v.addr   = ($urandom_range(0, 7) == 0) ? 12'($urandom) : addr_pool[$urandom_range(0, 5)];
            v.op     = 2'($urandom);
            v.wdata  = ($urandom_range(0, 3) == 0) ? 64'd0 :
                       ($urandom_range(0, 1) == 0) ? 64'($urandom_range(0, 7)) : {$urandom, $urandom};
            v.cyc    = {$urandom, $urandom};
            v.ret    = {$urandom, $urandom};
            v.retire = 1'($urandom);
            v.halt   = ($urandom_range(0, 5) == 0);
            v = model(v);
            run_access(v, $sformatf("rnd%0d", i));
            if ($urandom_range(0, 1) == 0) @(negedge clk);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/riscv_counter_ctrl.md
Name: riscv_counter_ctrl

Overview:
- Controller for the machine counters mcycle and minstret. Each counter is an external 64-bit register with a write port (priority) and an increment enable.
- Decodes CSR accesses from the CSR unit and runs a 3-state access FSM. It generates write and increment controls per counter, owns mcountinhibit, and returns read data.
- Sits between the CSR unit, the retire stage and the two counter instances.

Parameters:
CNT_W, 64, counter and CSR data width
ADDR_W, 12, CSR address width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
csr_req_i  in  1  CSR access request; held until csr_ack_o
csr_addr_i  in  ADDR_W  CSR address
csr_op_i  in  2  00 read, 01 write, 10 set, 11 clear
csr_wdata_i  in  CNT_W  write/set/clear operand
csr_ack_o  out  1  one-cycle completion pulse
csr_rdata_o  out  CNT_W  old CSR value, valid with ack
csr_illegal_o  out  1  access rejected, valid with ack
retire_i  in  1  one instruction retired this cycle
halt_i  in  1  debug halt, freezes both counters
cyc_value_i  in  CNT_W  current mcycle value
ret_value_i  in  CNT_W  current minstret value
cyc_incr_en_o  out  1  mcycle increment enable
cyc_write_en_o  out  1  mcycle write strobe
cyc_wdata_o  out  CNT_W  mcycle write data
ret_incr_en_o  out  1  minstret increment enable
ret_write_en_o  out  1  minstret write strobe
ret_wdata_o  out  CNT_W  minstret write data

Behaviour:
- Reset (rst=0, async):
  - FSM to IDLE; mcountinhibit=0; latched request cleared.
  - csr_ack_o, csr_illegal_o, csr_rdata_o, both write_en and both wdata = 0.
  - Incr enables are combinational and are 0 while rst=0.
- Address map:
  - 0xB00 mcycle (RW); 0xB02 minstret (RW); 0x320 mcountinhibit (RW).
  - 0xC00 cycle (RO alias); 0xC02 instret (RO alias).
  - Any other address is illegal.
- mcountinhibit: only bit0 (CY) and bit2 (IR) are implemented; all other bits read 0 and ignore writes.
- FSM states and transitions:
  - IDLE: on csr_req_i=1, latch addr/op/wdata and go to EXEC. Otherwise stay.
  - EXEC (1 cycle):
    - Select old = addressed value: cyc_value_i, ret_value_i, or {0…,IR,0,CY}.
    - Compute new: write = wdata; set = old|wdata; clear = old&~wdata.
    - Is-write = op==01, or op in {10,11} with wdata!=0. Set/clear with wdata==0 is a pure read.
    - Legal write: assert the matching write_en combinationally this cycle with wdata=new; mcountinhibit updates at the end-of-EXEC edge.
    - Register rdata=old, illegal flag. Go to ACK.
  - ACK (1 cycle): csr_ack_o=1, csr_rdata_o/csr_illegal_o valid. Go to IDLE.
- Latency: request sampled in IDLE at cycle N; write strobe in cycle N+1; ack in cycle N+2; next request sampled no earlier than N+3. The requester drops csr_req_i the cycle after ack.
- csr_req_i is ignored outside IDLE.
- Illegal access (unknown address, or is-write to 0xC00/0xC02):
  - no write_en, no inhibit change;
  - ack with illegal=1, rdata=0.
- A pure read of 0xC00/0xC02 is legal and returns the counter value.
- Increment enables (combinational):
  - cyc_incr_en_o = rst & ~CY & ~halt_i & ~cyc_write_en_o
  - ret_incr_en_o = rst & retire_i & ~IR & ~halt_i & ~ret_write_en_o
- Simultaneous write and increment: the write wins and that cycle's increment is dropped. The written value is exact, with no +1.
- A CSR instruction's own retire is handled like any other retire_i.
- Inhibit change takes effect from the cycle after EXEC.
- Counter wrap-around is owned by the counter; the controller applies no saturation.
- Read data is the counter value during EXEC (pre-write, pre-increment of that edge).
- Reset mid-operation: the access is aborted, with no ack and no write; the requester reissues.
- Both write_en outputs are never high together.

Test Plan:
- Release reset, halt_i=0, retire_i=0 -> cyc_incr_en_o=1 every cycle; ret_incr_en_o=0; all write_en=0; ack=0.
- Write 0xB00, wdata=0x100 at cycle N, cyc_value_i=0x40 in N+1 -> N+1: cyc_write_en_o=1, cyc_wdata_o=0x100, cyc_incr_en_o=0; N+2: ack=1, rdata=0x40, illegal=0.
- Set 0x320, wdata=0x5 -> from the cycle after EXEC cyc_incr_en_o=0 and ret_incr_en_o=0 even with retire_i=1; read 0x320 returns 0x5. Writing 0xFFFF then reading returns 0x5.
- Write 0xC02, wdata=1 -> no write_en in any cycle; ack with illegal=1, rdata=0. Read 0xC02 with ret_value_i=7 -> rdata=7, illegal=0.
- Clear 0xB02, wdata=0xFF, ret_value_i=0x1234, retire_i=1 -> EXEC: ret_write_en_o=1, ret_wdata_o=0x1200, ret_incr_en_o=0. Clear with wdata=0 -> no write_en, rdata=old.
- Drive rst low during EXEC -> write_en and ack go 0 immediately; mcountinhibit=0; after release, FSM is in IDLE and a new request completes normally.
